// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the DX-Ball game-flow controller.
// Holds the 3-bit state/status encoding (so the HUD can decode the status
// bus) and the default frame counts for the serve countdown and the hold
// period after a life loss or level clear.
package game_pkg;

  localparam int STATUS_W = 3;

  localparam logic [STATUS_W-1:0] ST_INIT  = 3'd0;
  localparam logic [STATUS_W-1:0] ST_SERVE = 3'd1;
  localparam logic [STATUS_W-1:0] ST_PLAY  = 3'd2;
  localparam logic [STATUS_W-1:0] ST_PAUSE = 3'd3;
  localparam logic [STATUS_W-1:0] ST_LOST  = 3'd4;
  localparam logic [STATUS_W-1:0] ST_CLEAR = 3'd5;
  localparam logic [STATUS_W-1:0] ST_OVER  = 3'd6;
  localparam logic [STATUS_W-1:0] ST_WIN   = 3'd7;

  localparam int DEFAULT_SERVE_FRAMES = 60;
  localparam int DEFAULT_HOLD_FRAMES  = 30;

endpackage : game_pkg

// File: rtl/game_sequencer_frame_timer.sv
// frame_timer: loadable down-counter that only counts on frame ticks.
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset (clears the count)
//   load       load load_val this cycle (wins over counting)
//   load_val   value loaded, i.e. dwell length minus one
//   run        counting enabled (owner is in a timed state)
//   frame_tick one-cycle pulse per video frame
//   expired    high on the frame tick that ends the dwell (count already 0)
module frame_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  input  logic         frame_tick,
  output logic         expired
);

  logic [W-1:0] count_r;

  // Down-counter: load has priority, then decrement on each tick until zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (run && frame_tick && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // A tick seen while the count is already zero is the last frame of the dwell.
  assign expired = run && frame_tick && (count_r == {W{1'b0}});

endmodule : frame_timer

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game-flow controller for the DX-Ball pipeline.
// Sequences INIT -> SERVE (countdown) -> PLAY, with PAUSE, LOST (life loss
// hold), CLEAR (level clear hold), OVER and WIN. Restarts on start from
// OVER/WIN without needing reset.
// Ports:
//   clk, reset       clock and synchronous active-low reset
//   frame_tick       one pulse per video frame; timers advance only on it
//   start            start/restart request
//   pause_req        pause toggle request
//   ball_lost        ball fell below the paddle
//   bricks_cleared   last brick of the level destroyed
//   status           current state encoding (see game_pkg)
//   initialize       hold objects in reset positions (INIT only)
//   play             physics/motion enable (PLAY only)
//   respawn          pulse on the first cycle of every SERVE
//   level_load       pulse on the first cycle of SERVE entered from INIT/CLEAR
//   lives, level     remaining lives and current level index
//   game_won         high while in WIN
module game_sequencer
  import game_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int MAX_LIVES    = 7,
  parameter int LIVES_W      = 3,
  parameter int NUM_LEVELS   = 4,
  parameter int LEVEL_W      = 2,
  parameter int SERVE_FRAMES = DEFAULT_SERVE_FRAMES,
  parameter int HOLD_FRAMES  = DEFAULT_HOLD_FRAMES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                start,
  input  logic                pause_req,
  input  logic                ball_lost,
  input  logic                bricks_cleared,
  output logic [STATUS_W-1:0] status,
  output logic                initialize,
  output logic                play,
  output logic                respawn,
  output logic                level_load,
  output logic [LIVES_W-1:0]  lives,
  output logic [LEVEL_W-1:0]  level,
  output logic                game_won
);

  // Counter sized for the longer dwell; kept at least one bit wide so that
  // single-frame dwells still elaborate.
  localparam int MAX_FRAMES = (SERVE_FRAMES > HOLD_FRAMES) ? SERVE_FRAMES : HOLD_FRAMES;
  localparam int TW_RAW     = $clog2(MAX_FRAMES);
  localparam int TW         = (TW_RAW < 1) ? 1 : TW_RAW;

  localparam logic [TW-1:0]      SERVE_LOAD = TW'(SERVE_FRAMES - 1);
  localparam logic [TW-1:0]      HOLD_LOAD  = TW'(HOLD_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_MAX  = LIVES_W'(MAX_LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);

  logic [STATUS_W-1:0] state_r;
  logic [STATUS_W-1:0] state_nxt_s;
  logic [LIVES_W-1:0]  lives_r;
  logic [LIVES_W-1:0]  lives_nxt_s;
  logic [LEVEL_W-1:0]  level_r;
  logic [LEVEL_W-1:0]  level_nxt_s;
  logic                respawn_r;
  logic                level_load_r;
  logic                run_s;
  logic                expired_s;
  logic                timed_nxt_s;
  logic                tmr_load_s;
  logic [TW-1:0]       tmr_val_s;
  logic                enter_serve_s;

  frame_timer #(
    .W(TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load_s),
    .load_val   (tmr_val_s),
    .run        (run_s),
    .frame_tick (frame_tick),
    .expired    (expired_s)
  );

  assign run_s = (state_r == ST_SERVE) || (state_r == ST_LOST) || (state_r == ST_CLEAR);

  // Next-state, lives and level update; at most one lives change per cycle.
  always_comb begin
    state_nxt_s = state_r;
    lives_nxt_s = lives_r;
    level_nxt_s = level_r;
    case (state_r)
      ST_INIT: begin
        lives_nxt_s = LIVES_INIT;
        level_nxt_s = {LEVEL_W{1'b0}};
        if (start) begin
          state_nxt_s = ST_SERVE;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_SERVE: begin
        if (expired_s) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_SERVE;
        end
      end
      ST_PLAY: begin
        // A clear in the same cycle as a loss counts as a clear.
        if (bricks_cleared) begin
          state_nxt_s = ST_CLEAR;
        end else if (ball_lost) begin
          state_nxt_s = ST_LOST;
          if (lives_r != {LIVES_W{1'b0}}) begin
            lives_nxt_s = lives_r - LIVES_W'(1);
          end else begin
            lives_nxt_s = {LIVES_W{1'b0}};
          end
        end else if (pause_req) begin
          state_nxt_s = ST_PAUSE;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (pause_req) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_LOST: begin
        if (expired_s) begin
          if (lives_r == {LIVES_W{1'b0}}) begin
            state_nxt_s = ST_OVER;
          end else begin
            state_nxt_s = ST_SERVE;
          end
        end else begin
          state_nxt_s = ST_LOST;
        end
      end
      ST_CLEAR: begin
        if (expired_s) begin
          if (level_r == LEVEL_LAST) begin
            state_nxt_s = ST_WIN;
          end else begin
            state_nxt_s = ST_SERVE;
            level_nxt_s = level_r + LEVEL_W'(1);
            if (lives_r >= LIVES_MAX) begin
              lives_nxt_s = LIVES_MAX;
            end else begin
              lives_nxt_s = lives_r + LIVES_W'(1);
            end
          end
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_OVER, ST_WIN: begin
        if (start) begin
          state_nxt_s = ST_INIT;
          lives_nxt_s = LIVES_INIT;
          level_nxt_s = {LEVEL_W{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Timer reload on every entry into a timed state, including LOST/CLEAR -> SERVE.
  always_comb begin
    timed_nxt_s   = (state_nxt_s == ST_SERVE) || (state_nxt_s == ST_LOST) ||
                    (state_nxt_s == ST_CLEAR);
    tmr_load_s    = timed_nxt_s && (state_nxt_s != state_r);
    enter_serve_s = (state_nxt_s == ST_SERVE) && (state_r != ST_SERVE);
    if (state_nxt_s == ST_SERVE) begin
      tmr_val_s = SERVE_LOAD;
    end else begin
      tmr_val_s = HOLD_LOAD;
    end
  end

  // State, counters and the SERVE-entry pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_INIT;
      lives_r      <= LIVES_INIT;
      level_r      <= {LEVEL_W{1'b0}};
      respawn_r    <= 1'b0;
      level_load_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      lives_r      <= lives_nxt_s;
      level_r      <= level_nxt_s;
      respawn_r    <= enter_serve_s;
      // No brick reload after a life loss; only fresh games and new levels.
      level_load_r <= enter_serve_s && ((state_r == ST_INIT) || (state_r == ST_CLEAR));
    end
  end

  assign status     = state_r;
  assign initialize = (state_r == ST_INIT);
  assign play       = (state_r == ST_PLAY);
  assign game_won   = (state_r == ST_WIN);
  assign respawn    = respawn_r;
  assign level_load = level_load_r;
  assign lives      = lives_r;
  assign level      = level_r;

endmodule : game_sequencer

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: the driver applies one input vector
// per clock, advances a frame-counting reference model and queues the
// expected outputs; the monitor pops and compares on each falling edge.
module tb_game_sequencer;

  localparam int P_START = 2;
  localparam int P_MAX   = 3;
  localparam int P_NLVL  = 2;
  localparam int P_SERVE = 2;
  localparam int P_HOLD  = 1;

  // Reference-model modes (same numbering as the visible status bus).
  localparam int M_INIT = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSE = 3;
  localparam int M_LOST = 4, M_CLEAR = 5, M_OVER = 6, M_WIN = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       pause_req = 1'b0;
  logic       ball_lost = 1'b0;
  logic       bricks_cleared = 1'b0;
  logic [2:0] status;
  logic       initialize;
  logic       play;
  logic       respawn;
  logic       level_load;
  logic [2:0] lives;
  logic [1:0] level;
  logic       game_won;

  game_sequencer #(
    .START_LIVES(P_START), .MAX_LIVES(P_MAX), .LIVES_W(3),
    .NUM_LEVELS(P_NLVL), .LEVEL_W(2),
    .SERVE_FRAMES(P_SERVE), .HOLD_FRAMES(P_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .pause_req(pause_req), .ball_lost(ball_lost), .bricks_cleared(bricks_cleared),
    .status(status), .initialize(initialize), .play(play), .respawn(respawn),
    .level_load(level_load), .lives(lives), .level(level), .game_won(game_won)
  );

  always #5 clk = ~clk;

  typedef struct {
    int status;
    int initialize;
    int play;
    int respawn;
    int level_load;
    int lives;
    int level;
    int game_won;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode, frames still to wait in the current timed mode.
  int m_mode   = M_INIT;
  int m_lives  = P_START;
  int m_level  = 0;
  int m_frames = 0;
  int m_resp   = 0;
  int m_ll     = 0;

  function automatic void model_step(input bit r, tk, st, pz, bl, bc);
    int prev;
    int nxt;
    prev = m_mode;
    nxt  = prev;
    if (!r) begin
      m_mode = M_INIT; m_lives = P_START; m_level = 0;
      m_frames = 0; m_resp = 0; m_ll = 0;
      return;
    end
    case (prev)
      M_INIT: begin
        m_lives = P_START; m_level = 0;
        if (st) nxt = M_SERVE;
      end
      M_SERVE: if (tk) begin
        m_frames--;
        if (m_frames == 0) nxt = M_PLAY;
      end
      M_PLAY: begin
        if (bc) nxt = M_CLEAR;
        else if (bl) begin
          nxt = M_LOST;
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        end else if (pz) nxt = M_PAUSE;
      end
      M_PAUSE: if (pz) nxt = M_PLAY;
      M_LOST: if (tk) begin
        m_frames--;
        if (m_frames == 0) nxt = (m_lives == 0) ? M_OVER : M_SERVE;
      end
      M_CLEAR: if (tk) begin
        m_frames--;
        if (m_frames == 0) begin
          if (m_level == P_NLVL - 1) nxt = M_WIN;
          else begin
            m_level++;
            m_lives = (m_lives + 1 > P_MAX) ? P_MAX : m_lives + 1;
            nxt = M_SERVE;
          end
        end
      end
      default: if (st) begin  // OVER, WIN
        nxt = M_INIT; m_lives = P_START; m_level = 0;
      end
    endcase
    if (nxt != prev) begin
      if (nxt == M_SERVE) m_frames = P_SERVE;
      if (nxt == M_LOST || nxt == M_CLEAR) m_frames = P_HOLD;
    end
    m_resp = (nxt == M_SERVE && prev != M_SERVE) ? 1 : 0;
    m_ll   = (m_resp == 1 && (prev == M_INIT || prev == M_CLEAR)) ? 1 : 0;
    m_mode = nxt;
  endfunction

  task automatic step(input bit r, tk, st, pz, bl, bc);
    exp_t e;
    reset = r; frame_tick = tk; start = st;
    pause_req = pz; ball_lost = bl; bricks_cleared = bc;
    @(posedge clk);
    model_step(r, tk, st, pz, bl, bc);
    e.status     = m_mode;
    e.initialize = (m_mode == M_INIT) ? 1 : 0;
    e.play       = (m_mode == M_PLAY) ? 1 : 0;
    e.game_won   = (m_mode == M_WIN) ? 1 : 0;
    e.respawn    = m_resp;
    e.level_load = m_ll;
    e.lives      = m_lives;
    e.level      = m_level;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: every cycle presents a full output vector to compare.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("status",     int'(status),     e.status);
      check("initialize", int'(initialize), e.initialize);
      check("play",       int'(play),       e.play);
      check("respawn",    int'(respawn),    e.respawn);
      check("level_load", int'(level_load), e.level_load);
      check("lives",      int'(lives),      e.lives);
      check("level",      int'(level),      e.level);
      check("game_won",   int'(game_won),   e.game_won);
    end
  end

  initial begin
    // Reset, then start: SERVE for two ticks, then PLAY.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Two losses -> OVER, then restart to INIT.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    // Simultaneous loss+clear, level up, then win.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    // Pause, ignored loss/clear while paused, resume.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Lose a life, freeze SERVE with no frame ticks, then two ticks.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Reset while in LOST.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 24) == 0));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_game_sequencer
